// File: rtl/ps2_pkg.sv
// Shared constants, FSM state and event type for the PS/2 key decoder.
package ps2_pkg;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_00 = 8'h00;
  localparam logic [7:0] BYTE_FF = 8'hFF;
  localparam logic [7:0] BYTE_AA = 8'hAA;
  localparam logic [7:0] BYTE_FA = 8'hFA;
  localparam logic [7:0] BYTE_EE = 8'hEE;
  localparam logic [7:0] BYTE_FE = 8'hFE;

  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_Q     = 8'h15;
  localparam logic [7:0] KEY_E     = 8'h24;
  localparam logic [7:0] KEY_Z     = 8'h1A;
  localparam logic [7:0] KEY_C     = 8'h21;
  localparam logic [7:0] KEY_SPACE = 8'h29;

  localparam logic [7:0] ARROW_UP    = 8'h75;
  localparam logic [7:0] ARROW_LEFT  = 8'h6B;
  localparam logic [7:0] ARROW_DOWN  = 8'h72;
  localparam logic [7:0] ARROW_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0
  } prefix_state_t;

  typedef struct packed {
    logic       rpt;
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

  function automatic logic [8:0] key_onehot(input logic [7:0] code);
    key_onehot = '0;
    case (code)
      KEY_W:     key_onehot[0] = 1'b1;
      KEY_A:     key_onehot[1] = 1'b1;
      KEY_S:     key_onehot[2] = 1'b1;
      KEY_D:     key_onehot[3] = 1'b1;
      KEY_Q:     key_onehot[4] = 1'b1;
      KEY_E:     key_onehot[5] = 1'b1;
      KEY_Z:     key_onehot[6] = 1'b1;
      KEY_C:     key_onehot[7] = 1'b1;
      KEY_SPACE: key_onehot[8] = 1'b1;
      default:   key_onehot = '0;
    endcase
  endfunction

  function automatic logic [3:0] arrow_onehot(input logic [7:0] code);
    arrow_onehot = '0;
    case (code)
      ARROW_UP:    arrow_onehot[0] = 1'b1;
      ARROW_LEFT:  arrow_onehot[1] = 1'b1;
      ARROW_DOWN:  arrow_onehot[2] = 1'b1;
      ARROW_RIGHT: arrow_onehot[3] = 1'b1;
      default:     arrow_onehot = '0;
    endcase
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous event FIFO with wrap-bit pointers; head is read straight from the register array.
module key_event_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  key_event_t din,
  output logic       full,
  output logic       empty,
  output key_event_t head
);

  localparam int unsigned AW = $clog2(DEPTH);

  key_event_t    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '{default: '0};
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scancode decoder: prefix FSM, held-key bitmap and event FIFO.
// Define PS2_EXT_EN to enable E0-extended decoding and arrow-key held bits.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned PREFIX_TIMEOUT = 50000
) (
  input  logic       master_clk,
  input  logic       rst,
  input  logic [7:0] rxdata,
  input  logic       datafetched,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_break,
  output logic       ev_ext,
  output logic       ev_repeat,
  output logic [8:0] held,
  output logic       err,
  output logic       overflow
);

  localparam int unsigned   TW       = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT - 1);

  prefix_state_t state, state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          is_e0, is_f0, is_ovr, is_ack, timeout;
  logic          emit, emit_brk, emit_ext, err_now;
  logic [8:0]    held_base, base_hit;
  logic [3:0]    held_arr, arr_hit;
  key_event_t    ev_in, ev_head;
  logic          fifo_full, fifo_empty, pop;

  assign is_e0   = (rxdata == BYTE_E0);
  assign is_f0   = (rxdata == BYTE_F0);
  assign is_ovr  = (rxdata == BYTE_00) || (rxdata == BYTE_FF);
  assign is_ack  = (rxdata == BYTE_AA) || (rxdata == BYTE_FA) ||
                   (rxdata == BYTE_EE) || (rxdata == BYTE_FE);
  assign timeout = !datafetched && (state != ST_IDLE) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (datafetched) begin
      if (is_e0) begin
`ifdef PS2_EXT_EN
        state_nxt = ST_GOT_E0;
`endif
      end else if (is_f0) begin
        if (state == ST_IDLE)        state_nxt = ST_GOT_F0;
        else if (state == ST_GOT_E0) state_nxt = ST_GOT_E0F0;
      end else begin
        state_nxt = ST_IDLE;
      end
    end else if (timeout) begin
      state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    emit     = 1'b0;
    emit_brk = 1'b0;
    emit_ext = 1'b0;
    err_now  = 1'b0;
    if (datafetched) begin
      if (is_e0) begin
`ifdef PS2_EXT_EN
        err_now = (state != ST_IDLE);
`endif
      end else if (is_f0) begin
        err_now = (state == ST_GOT_F0) || (state == ST_GOT_E0F0);
      end else if (state == ST_IDLE) begin
        err_now = is_ovr;
        emit    = !is_ovr && !is_ack;
      end else begin
        emit     = 1'b1;
        emit_brk = (state == ST_GOT_F0) || (state == ST_GOT_E0F0);
`ifdef PS2_EXT_EN
        emit_ext = (state == ST_GOT_E0) || (state == ST_GOT_E0F0);
`endif
      end
    end else begin
      err_now = timeout;
    end
  end

  // Strobes always restart the window, so a byte on the expiry cycle beats the timeout.
  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst)                                        tmo_cnt <= '0;
    else if (datafetched || state == ST_IDLE || timeout) tmo_cnt <= '0;
    else                                             tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign base_hit = emit_ext ? 9'd0 : key_onehot(rxdata);
`ifdef PS2_EXT_EN
  assign arr_hit  = emit_ext ? arrow_onehot(rxdata) : 4'd0;
`else
  assign arr_hit  = 4'd0;
`endif
  assign held = held_base | {5'd0, held_arr};

  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) begin
      held_base <= '0;
      held_arr  <= '0;
    end else if (emit) begin
      if (emit_brk) begin
        held_base <= held_base & ~base_hit;
        held_arr  <= held_arr & ~arr_hit;
      end else begin
        held_base <= held_base | base_hit;
        held_arr  <= held_arr | arr_hit;
      end
    end
  end

  assign ev_in.rpt  = !emit_brk && |((base_hit | {5'd0, arr_hit}) & held);
  assign ev_in.ext  = emit_ext;
  assign ev_in.brk  = emit_brk;
  assign ev_in.code = rxdata;

  assign ev_valid = !fifo_empty;
  assign pop      = ev_valid && ev_ready;

  key_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (master_clk),
    .rst   (rst),
    .push  (emit),
    .pop   (pop),
    .din   (ev_in),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (ev_head)
  );

  assign ev_code   = ev_head.code;
  assign ev_break  = ev_head.brk;
  assign ev_ext    = ev_head.ext;
  assign ev_repeat = ev_head.rpt;

  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) begin
      err      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      err      <= err_now;
      overflow <= overflow | (emit && fifo_full && !pop);
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder; events are compared as {repeat, ext, break, code}.
module tb_ps2_key_decoder;

  localparam int unsigned PT = 20;

  logic       master_clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rxdata = 8'h00;
  logic       datafetched = 1'b0;
  logic       ev_ready = 1'b0;
  logic       ev_valid, ev_code_dummy;
  logic [7:0] ev_code;
  logic       ev_break, ev_ext, ev_repeat, err, overflow;
  logic [8:0] held;

  int tests = 0;
  int fails = 0;

  assign ev_code_dummy = 1'b0;

  ps2_key_decoder #(.FIFO_DEPTH(4), .PREFIX_TIMEOUT(PT)) dut (
    .master_clk  (master_clk),
    .rst         (rst),
    .rxdata      (rxdata),
    .datafetched (datafetched),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_code     (ev_code),
    .ev_break    (ev_break),
    .ev_ext      (ev_ext),
    .ev_repeat   (ev_repeat),
    .held        (held),
    .err         (err),
    .overflow    (overflow)
  );

  always #5 master_clk = ~master_clk;

  task automatic do_reset();
    datafetched = 1'b0;
    ev_ready    = 1'b0;
    rst         = 1'b0;
    @(negedge master_clk);
    @(negedge master_clk);
    rst = 1'b1;
    @(negedge master_clk);
  endtask

  // Called on a negedge; returns on the next negedge with the byte taken at the posedge between.
  task automatic send_byte(input logic [7:0] b);
    rxdata      = b;
    datafetched = 1'b1;
    @(negedge master_clk);
    datafetched = 1'b0;
  endtask

  task automatic pop_event(output logic [10:0] e, output bit got);
    got = 1'b0;
    e   = '0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (ev_valid) begin
        e        = {ev_repeat, ev_ext, ev_break, ev_code};
        got      = 1'b1;
        ev_ready = 1'b1;
        @(negedge master_clk);
        ev_ready = 1'b0;
      end else begin
        @(negedge master_clk);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    send_byte(8'h1D);
    send_byte(8'hF0);
    rst = 1'b0;
    #1;
    tests++;
    if ({ev_valid, ev_code, ev_break, ev_ext, ev_repeat, held, err, overflow} !== 22'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h required 0",
               {ev_valid, ev_code, ev_break, ev_ext, ev_repeat, held, err, overflow});
    end
    @(negedge master_clk);
    rst = 1'b1;
    @(negedge master_clk);
    send_byte(8'h1C);
    tests++;
    if (held !== 9'h002) begin
      fails++; $display("FAIL reset_prefix_held: got %h required 002", held);
    end
    begin
      logic [10:0] e; bit got;
      pop_event(e, got);
      tests++;
      if (!got || e !== 11'h01C) begin
        fails++; $display("FAIL reset_prefix_event: got=%0d ev=%h required 01C", got, e);
      end
    end
    tests++;
    if (ev_valid !== 1'b0) begin
      fails++; $display("FAIL reset_fifo_empty: got %b required 0", ev_valid);
    end
  endtask

  task automatic test_make_break();
    logic [10:0] e; bit got;
    do_reset();
    send_byte(8'h1D);
    tests++;
    if (held !== 9'h001 || ev_valid !== 1'b1) begin
      fails++; $display("FAIL mb_make_held: held=%h valid=%b required 001/1", held, ev_valid);
    end
    send_byte(8'hF0);
    send_byte(8'h1D);
    tests++;
    if (held !== 9'h000) begin
      fails++; $display("FAIL mb_break_held: got %h required 000", held);
    end
    pop_event(e, got);
    tests++;
    if (!got || e !== 11'h01D) begin
      fails++; $display("FAIL mb_ev_make: got=%0d ev=%h required 01D", got, e);
    end
    pop_event(e, got);
    tests++;
    if (!got || e !== 11'h11D) begin
      fails++; $display("FAIL mb_ev_break: got=%0d ev=%h required 11D", got, e);
    end
  endtask

  task automatic test_repeat();
    logic [10:0] e; bit got;
    logic [10:0] exp_ev [3];
    exp_ev[0] = 11'h01D; exp_ev[1] = 11'h41D; exp_ev[2] = 11'h41D;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h1D);
      tests++;
      if (held !== 9'h001) begin
        fails++; $display("FAIL rep_held_%0d: got %h required 001", i, held);
      end
    end
    for (int i = 0; i < 3; i++) begin
      pop_event(e, got);
      tests++;
      if (!got || e !== exp_ev[i]) begin
        fails++; $display("FAIL rep_ev_%0d: got=%0d ev=%h required %h", i, got, e, exp_ev[i]);
      end
    end
  endtask

  task automatic test_ext();
    logic [10:0] e; bit got;
    logic [10:0] exp_make, exp_brk;
    logic [8:0]  exp_held_mid;
`ifdef PS2_EXT_EN
    exp_make = 11'h275; exp_brk = 11'h375; exp_held_mid = 9'h001;
`else
    exp_make = 11'h075; exp_brk = 11'h175; exp_held_mid = 9'h000;
`endif
    do_reset();
    send_byte(8'hE0);
    tests++;
    if (err !== 1'b0 || ev_valid !== 1'b0) begin
      fails++; $display("FAIL ext_prefix_quiet: err=%b valid=%b required 0/0", err, ev_valid);
    end
    send_byte(8'h75);
    tests++;
    if (held !== exp_held_mid) begin
      fails++; $display("FAIL ext_make_held: got %h required %h", held, exp_held_mid);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    tests++;
    if (held !== 9'h000) begin
      fails++; $display("FAIL ext_break_held: got %h required 000", held);
    end
    pop_event(e, got);
    tests++;
    if (!got || e !== exp_make) begin
      fails++; $display("FAIL ext_ev_make: got=%0d ev=%h required %h", got, e, exp_make);
    end
    pop_event(e, got);
    tests++;
    if (!got || e !== exp_brk) begin
      fails++; $display("FAIL ext_ev_break: got=%0d ev=%h required %h", got, e, exp_brk);
    end
`ifdef PS2_EXT_EN
    // w and up-arrow share held[0]; releasing one source must not clear the other.
    send_byte(8'h1D);
    send_byte(8'hE0);
    send_byte(8'h75);
    send_byte(8'hF0);
    send_byte(8'h1D);
    tests++;
    if (held !== 9'h001) begin
      fails++; $display("FAIL ext_or_held: got %h required 001", held);
    end
    pop_event(e, got);
    pop_event(e, got);
    tests++;
    if (!got || e !== 11'h675) begin
      fails++; $display("FAIL ext_or_repeat: got=%0d ev=%h required 675", got, e);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    tests++;
    if (held !== 9'h000) begin
      fails++; $display("FAIL ext_or_clear: got %h required 000", held);
    end
`endif
  endtask

  task automatic test_timeout();
    logic [10:0] e; bit got;
    int k; bit seen;
    do_reset();
    send_byte(8'hF0);
    k = 0; seen = 1'b0;
    for (int i = 1; i <= int'(PT) + 4 && !seen; i++) begin
      @(negedge master_clk);
      if (err) begin seen = 1'b1; k = i; end
    end
    tests++;
    if (!seen || k < int'(PT) || k > int'(PT) + 1) begin
      fails++; $display("FAIL tmo_err_pulse: seen=%0d cycle=%0d required %0d..%0d", seen, k, PT, PT + 1);
    end
    @(negedge master_clk);
    tests++;
    if (err !== 1'b0 || ev_valid !== 1'b0) begin
      fails++; $display("FAIL tmo_err_one_cycle: err=%b valid=%b required 0/0", err, ev_valid);
    end
    send_byte(8'h1C);
    tests++;
    if (held !== 9'h002) begin
      fails++; $display("FAIL tmo_make_held: got %h required 002", held);
    end
    pop_event(e, got);
    tests++;
    if (!got || e !== 11'h01C) begin
      fails++; $display("FAIL tmo_make_ev: got=%0d ev=%h required 01C", got, e);
    end
    // Byte lands exactly on the expiry cycle: decoded as break, no error.
    send_byte(8'hF0);
    repeat (PT - 1) @(negedge master_clk);
    send_byte(8'h1C);
    tests++;
    if (err !== 1'b0 || held !== 9'h000) begin
      fails++; $display("FAIL tmo_strobe_wins: err=%b held=%h required 0/000", err, held);
    end
    pop_event(e, got);
    tests++;
    if (!got || e !== 11'h11C) begin
      fails++; $display("FAIL tmo_strobe_ev: got=%0d ev=%h required 11C", got, e);
    end
  endtask

  task automatic test_overflow();
    logic [10:0] e; bit got;
    logic [7:0] codes [5];
    logic [10:0] exp_tail [4];
    codes[0] = 8'h15; codes[1] = 8'h24; codes[2] = 8'h1A; codes[3] = 8'h21; codes[4] = 8'h29;
    exp_tail[0] = 11'h424; exp_tail[1] = 11'h41A; exp_tail[2] = 11'h421; exp_tail[3] = 11'h429;
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(codes[i]);
    tests++;
    if (overflow !== 1'b0) begin
      fails++; $display("FAIL ovf_not_yet: got %b required 0", overflow);
    end
    send_byte(codes[4]);
    tests++;
    if (overflow !== 1'b1 || held !== 9'h1F0) begin
      fails++; $display("FAIL ovf_set_held: ovf=%b held=%h required 1/1F0", overflow, held);
    end
    for (int i = 0; i < 4; i++) begin
      pop_event(e, got);
      tests++;
      if (!got || e !== {3'b000, codes[i]}) begin
        fails++; $display("FAIL ovf_pop_%0d: got=%0d ev=%h required %h", i, got, e, {3'b000, codes[i]});
      end
    end
    tests++;
    if (ev_valid !== 1'b0) begin
      fails++; $display("FAIL ovf_drained: got %b required 0", ev_valid);
    end
    for (int i = 0; i < 4; i++) send_byte(codes[i]);
    ev_ready = 1'b1;
    send_byte(codes[4]);
    ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pop_event(e, got);
      tests++;
      if (!got || e !== exp_tail[i]) begin
        fails++; $display("FAIL ovf_pushpop_%0d: got=%0d ev=%h required %h", i, got, e, exp_tail[i]);
      end
    end
    tests++;
    if (ev_valid !== 1'b0 || overflow !== 1'b1) begin
      fails++; $display("FAIL ovf_sticky: valid=%b ovf=%b required 0/1", ev_valid, overflow);
    end
  endtask

  task automatic test_errors();
    logic [10:0] e; bit got;
    do_reset();
    send_byte(8'hF0);
    send_byte(8'hF0);
    tests++;
    if (err !== 1'b1) begin
      fails++; $display("FAIL err_f0f0: got %b required 1", err);
    end
    send_byte(8'h00);
    tests++;
    if (err !== 1'b0 || ev_valid !== 1'b1) begin
      fails++; $display("FAIL err_f0_break_00: err=%b valid=%b required 0/1", err, ev_valid);
    end
    pop_event(e, got);
    tests++;
    if (!got || e !== 11'h100) begin
      fails++; $display("FAIL err_break_ev: got=%0d ev=%h required 100", got, e);
    end
    send_byte(8'h00);
    tests++;
    if (err !== 1'b1 || ev_valid !== 1'b0) begin
      fails++; $display("FAIL err_idle_00: err=%b valid=%b required 1/0", err, ev_valid);
    end
    send_byte(8'hFF);
    tests++;
    if (err !== 1'b1 || ev_valid !== 1'b0) begin
      fails++; $display("FAIL err_idle_ff: err=%b valid=%b required 1/0", err, ev_valid);
    end
    send_byte(8'hAA);
    send_byte(8'hFA);
    send_byte(8'hEE);
    send_byte(8'hFE);
    tests++;
    if (err !== 1'b0 || ev_valid !== 1'b0) begin
      fails++; $display("FAIL err_ack_silent: err=%b valid=%b required 0/0", err, ev_valid);
    end
`ifdef PS2_EXT_EN
    send_byte(8'hF0);
    send_byte(8'hE0);
    tests++;
    if (err !== 1'b1) begin
      fails++; $display("FAIL err_f0e0: got %b required 1", err);
    end
    send_byte(8'h75);
    pop_event(e, got);
    tests++;
    if (!got || e !== 11'h275) begin
      fails++; $display("FAIL err_f0e0_recover: got=%0d ev=%h required 275", got, e);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [10:0] e; bit got;
    do_reset();
    send_byte(8'h1D);
    send_byte(8'hF0);
    send_byte(8'h1D);
    send_byte(8'h1B);
    tests++;
    if (held !== 9'h004) begin
      fails++; $display("FAIL b2b_held: got %h required 004", held);
    end
    pop_event(e, got);
    pop_event(e, got);
    tests++;
    if (!got || e !== 11'h11D) begin
      fails++; $display("FAIL b2b_break: got=%0d ev=%h required 11D", got, e);
    end
    pop_event(e, got);
    tests++;
    if (!got || e !== 11'h01B) begin
      fails++; $display("FAIL b2b_make: got=%0d ev=%h required 01B", got, e);
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_repeat();
    test_ext();
    test_timeout();
    test_overflow();
    test_errors();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Decodes the raw byte stream from the PS/2 `keyboard` receiver into key events with make/break and extended flags. Feeds the paint control logic. Maintains a held-key bitmap for the movement keys and buffers events in a small FIFO with a valid/ready handshake. Runs on `master_clk` between `keyboard` and the cursor/colour logic.

## Interface
- `FIFO_DEPTH`, default 4: event FIFO entries; power of two, 2..16.
- `PREFIX_TIMEOUT`, default 50000: cycles allowed between a prefix byte and its completing byte (1 ms at 50 MHz).
- `master_clk` in 1: 50 MHz clock; all logic on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `rxdata` in 8: received scancode byte; valid when `datafetched`=1.
- `datafetched` in 1: one-cycle byte strobe; each high cycle is one byte, back-to-back allowed.
- `ev_valid` out 1: FIFO head holds an event.
- `ev_ready` in 1: consumer accepts the head this cycle.
- `ev_code` out 8: scancode of the head event.
- `ev_break` out 1: head is a release (F0-prefixed).
- `ev_ext` out 1: head was E0-prefixed.
- `ev_repeat` out 1: head is a make of a key already held (typematic).
- `held` out 9: held bitmap. Bits 0..8 = w(1D) a(1C) s(1B) d(23) q(15) e(24) z(1A) c(21) space(29).
- `err` out 1: one-cycle pulse on protocol error or timeout.
- `overflow` out 1: sticky; set when an event is dropped on a full FIFO; cleared only by reset.

## Operation
- Prefix FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. It acts only on cycles with `datafetched`=1, except for the timeout.
- IDLE: E0 goes to GOT_E0. F0 goes to GOT_F0. 00 or FF (keyboard overrun) is dropped, pulses `err`, and stays IDLE. AA, FA, EE and FE are dropped silently. Any other byte emits a make event with ext=0.
- GOT_E0: F0 goes to GOT_E0F0. Any other byte except E0 emits a make event with ext=1, then IDLE.
- GOT_F0: any byte other than E0 or F0 emits a break event with ext=0, then IDLE.
- GOT_E0F0: any byte other than E0 or F0 emits a break event with ext=1, then IDLE.
- E0 received in any non-IDLE state: pulse `err`, go to GOT_E0.
- F0 received in GOT_F0 or GOT_E0F0: pulse `err`, state unchanged.
- Timeout: a counter runs only in non-IDLE states and clears on every accepted byte. When it reaches PREFIX_TIMEOUT, return to IDLE and pulse `err`. If a strobe arrives on the same cycle, the strobe wins: the byte is decoded in the current state and no timeout occurs.
- Held bitmap:
  - Make of a mapped code sets its bit. Break clears it.
  - `ev_repeat` = the bit was already set at the make.
  - Break of a key not held: bit stays 0, event still emitted.
  - `held` updates even when the FIFO is full.
- FIFO entry is 11 bits {repeat, ext, break, code}.
  - Push on event; pop when `ev_valid` and `ev_ready` are both 1.
  - Full and push without pop: drop the new event and set `overflow`.
  - Full with push and pop on the same cycle: both occur, no drop.
  - Empty with push: entry written, no bypass.
- Pointers are log2(FIFO_DEPTH) bits plus one wrap bit. Full = MSBs differ and lower bits equal.

## Timing
- Reset values: `ev_valid`=0, `ev_code`=0, `ev_break`=0, `ev_ext`=0, `ev_repeat`=0, `held`=0, `err`=0, `overflow`=0. FSM in IDLE, FIFO empty, timeout counter 0.
- A byte strobed at edge N is decoded and written at edge N. `ev_valid` and `held` reflect it after edge N, i.e. 1-cycle latency.
- `ev_*` outputs are registered FIFO head fields. They remain stable while `ev_valid`=1 and `ev_ready`=0.
- `err` is high exactly for the cycle after the offending edge.
- Reset mid-prefix or with the FIFO non-empty discards all state immediately.

## Configuration
- `PS2_EXT_EN` defined:
  - E0 handling as above.
  - Arrow keys also drive `held`: E0 75 → bit 0, E0 6B → bit 1, E0 72 → bit 2, E0 74 → bit 3.
  - Non-extended and extended presses of keys sharing a bit are OR'd, with one set/clear flag per source.
- `PS2_EXT_EN` undefined:
  - E0 is dropped silently with no state change, and GOT_E0/GOT_E0F0 are never entered.
  - `ev_ext` is tied to 0. The following byte decodes as non-extended.
  - Arrow keys map nothing.

## Structure
- Package `ps2_pkg`:
  - Prefix/control byte constants E0, F0, 00, FF, AA, FA, EE, FE.
  - The nine key codes and four arrow codes.
  - FSM state enum.
  - Packed event struct {repeat, ext, brk, code[7:0]}.
- Sub-module `key_event_fifo` holds the parameterised sync FIFO: push, pop, full, empty, head. The decoder instantiates one.

## Test plan
- Bytes 1D, then F0 1D → two events {1D, make, rep=0} then {1D, break}. `held[0]` goes 1 then 0.
- Bytes 1D, 1D, 1D → three events with repeat=0, 1, 1. `held[0]`=1 throughout.
- `PS2_EXT_EN` set, bytes E0 75 then E0 F0 75 → {75, ext=1, make} then {75, ext=1, break}. `held[0]` pulses. With the macro undefined: {75, ext=0} events, `held`=0.
- F0, then silence for PREFIX_TIMEOUT cycles, then 1C → `err` pulse, then make event 1C with `held[1]`=1.
- `ev_ready`=0 and 5 makes with FIFO_DEPTH=4 → 4 entries held, `overflow`=1, first 4 codes pop in order. Full FIFO with push and pop on the same cycle: no drop.
- Bytes F0 E0 and 00 → two `err` pulses, no events. The FSM ends in IDLE after the next byte completes.
